// File: rtl/uart_pkg.sv
// Shared types and frame-geometry helpers for the FIFO byte serializer.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_STOP_BITS    = 1;

   // Bit periods in one frame: start + data + stop.
   function automatic int frame_bits(input int data_width, input int stop_bits);
      return 1 + data_width + stop_bits;
   endfunction

   localparam int FRAME_BITS = frame_bits(DEF_DATA_WIDTH, DEF_STOP_BITS);

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/fifo_byte_serializer.sv
// Pops bytes from the width-converting FIFO and sends each one as an async serial
// frame (start bit, data LSB first, stop bits) on tx.
module fifo_byte_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int STOP_BITS    = DEF_STOP_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  rd,
   output logic                  tx,
   output logic                  busy
);

   localparam int FRAME_LEN = frame_bits(DATA_WIDTH, STOP_BITS);
   localparam int BW        = $clog2(FRAME_LEN);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(FRAME_LEN - 2);

   tx_state_t             state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BW-1:0]         bit_cnt;
   logic                  tick;
   logic                  timer_clear;
   logic                  frame_done;
   logic                  take;

   assign timer_clear = (state == IDLE);

   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clear),
      .tick  (tick)
   );

   // bit_cnt keeps counting through the stop bits, so the last stop period
   // is recognised without a separate stop counter.
   assign frame_done = (state == STOP) && tick && (bit_cnt == LAST_STOP);
   assign take       = !reset && enable && !empty && ((state == IDLE) || frame_done);
   assign rd         = take;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  shift_reg <= r_data;
                  bit_cnt   <= '0;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx      <= shift_reg[0];
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt == LAST_DATA) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                  end
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            STOP: begin
               if (frame_done) begin
                  bit_cnt <= '0;
                  if (take) begin
                     // Back-to-back frame: next start bit follows the last stop cycle.
                     shift_reg <= r_data;
                     tx        <= 1'b0;
                     state     <= START;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else if (tick) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: queue-based FIFO model upstream, line decoder
// downstream comparing decoded bytes against the FIFO pop order.
module tb_fifo_byte_serializer;

   localparam int DW     = 8;
   localparam int CPB    = 4;
   localparam int FRAME1 = (1 + DW + 1) * CPB;
   localparam int FRAME2 = (1 + DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          empty;
   logic [DW-1:0] r_data;
   logic          rd;
   logic          tx;
   logic          busy;

   logic          enable2;
   logic          empty2;
   logic [DW-1:0] r_data2;
   logic          rd2;
   logic          tx2;
   logic          busy2;

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;
   int rd_count    = 0;
   int busy_cycles = 0;
   bit pop_pending = 1'b0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int            frame_starts[$];

   always #5 clk = ~clk;

   fifo_byte_serializer #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (1)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .empty  (empty),
      .r_data (r_data),
      .rd     (rd),
      .tx     (tx),
      .busy   (busy)
   );

   fifo_byte_serializer #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (2)
   ) dut2 (
      .clk    (clk),
      .reset  (reset),
      .enable (enable2),
      .empty  (empty2),
      .r_data (r_data2),
      .rd     (rd2),
      .tx     (tx2),
      .busy   (busy2)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic void fifo_refresh();
      empty  = (fifo_q.size() == 0);
      r_data = empty ? '0 : fifo_q[0];
   endfunction

   task automatic push_byte(input logic [DW-1:0] b);
      fifo_q.push_back(b);
      fifo_refresh();
   endtask

   // Byte side reads the low byte of each 16-bit write first.
   task automatic push_word(input logic [15:0] w);
      push_byte(w[7:0]);
      push_byte(w[15:8]);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_rd(input string name);
      int n;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (rd === 1'b1) break;
         n++;
      end
      if (n >= 200) check({name, "_timeout"}, 1, 0);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(fifo_q.size() == 0 && exp_q.size() == 0 && busy === 1'b0 &&
                   rd === 1'b0 && !pop_pending) && n < 3000);
      if (n >= 3000) check({name, "_timeout"}, 1, 0);
   endtask

   // FIFO model: rd seen mid-cycle pops on the following edge.
   always @(negedge clk) begin
      if (rd === 1'b1) begin
         rd_count++;
         check("rd_while_empty", empty, 0);
         pop_pending = 1'b1;
      end
      if (rd2 === 1'b1) check("rd2_while_empty", empty2, 0);
      if (busy === 1'b1) busy_cycles++;
   end

   always @(posedge clk) begin
      cycle++;
      #1;
      if (pop_pending) begin
         pop_pending = 1'b0;
         if (fifo_q.size() > 0) begin
            exp_q.push_back(fifo_q.pop_front());
            fifo_refresh();
         end
      end
   end

   // Line decoder: rebuilds a frame from tx alone and checks every cycle of it.
   task automatic monitor_frame();
      logic [DW-1:0] got;
      logic          shape_ok;
      logic          level;
      int            pos;
      got      = '0;
      shape_ok = 1'b1;
      frame_starts.push_back(cycle);
      for (int k = 0; k < FRAME1; k++) begin
         if (k > 0) begin
            @(negedge clk);
            if (reset !== 1'b0) return;
         end
         pos = k / CPB;
         if (pos >= 1 && pos <= DW && (k % CPB) == 0) got[pos-1] = tx;
         if (pos == 0) level = 1'b0;
         else if (pos > DW) level = 1'b1;
         else level = got[pos-1];
         if (tx !== level || busy !== 1'b1) shape_ok = 1'b0;
      end
      check("frame_shape", shape_ok, 1);
      if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
      else check("frame_byte", got, exp_q.pop_front());
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset !== 1'b0 || tx !== 1'b0) continue;
         monitor_frame();
      end
   end

   initial begin
      #1000000;
      miscompares++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1);
   end

   initial begin
      int            rd0;
      int            fs0;
      int            busy0;
      int            n;
      int            pos;
      logic [DW-1:0] b;
      logic [15:0]   w;
      logic          lvl;

      reset   = 1'b1;
      enable  = 1'b0;
      enable2 = 1'b0;
      empty2  = 1'b1;
      r_data2 = '0;
      fifo_refresh();
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      // Reset state and idle line with an empty FIFO.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_tx", tx, 1);
         check("idle_rd", rd, 0);
         check("idle_busy", busy, 0);
      end

      // Single byte 0xA5.
      step();
      rd0   = rd_count;
      busy0 = busy_cycles;
      fs0   = frame_starts.size();
      push_byte(8'hA5);
      enable = 1'b1;
      wait_idle("t2");
      step();
      check("t2_rd_pulses", rd_count - rd0, 1);
      check("t2_busy_cycles", busy_cycles - busy0, FRAME1);
      check("t2_frames", frame_starts.size() - fs0, 1);

      // One 16-bit word -> two back-to-back frames.
      rd0 = rd_count;
      fs0 = frame_starts.size();
      push_word(16'hF18F);
      wait_idle("t3");
      step();
      check("t3_rd_pulses", rd_count - rd0, 2);
      check("t3_frames", frame_starts.size() - fs0, 2);
      if (frame_starts.size() - fs0 == 2)
         check("t3_gap", frame_starts[fs0+1] - frame_starts[fs0], FRAME1);
      check("t3_empty", empty, 1);

      // enable drops during the first frame's data bits.
      rd0 = rd_count;
      fs0 = frame_starts.size();
      push_word(16'h3C5A);
      push_word(16'h0FF0);
      wait_rd("t4_rd");
      repeat (10) @(posedge clk);
      #2 enable = 1'b0;
      repeat (80) @(posedge clk);
      @(negedge clk);
      check("t4_rd_hold", rd_count - rd0, 1);
      check("t4_frames_hold", frame_starts.size() - fs0, 1);
      check("t4_busy_idle", busy, 0);
      check("t4_tx_idle", tx, 1);
      check("t4_fifo_left", fifo_q.size(), 3);
      step();
      enable = 1'b1;
      wait_idle("t4_drain");
      step();
      check("t4_rd_total", rd_count - rd0, 4);
      check("t4_frames_total", frame_starts.size() - fs0, 4);

      // Reset in the middle of data bit 3; the in-flight byte is lost.
      fs0 = frame_starts.size();
      push_word(16'h6BD2);
      wait_rd("t5_rd");
      repeat (18) @(posedge clk);
      #2;
      reset  = 1'b1;
      enable = 1'b0;
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("t5_tx_after_reset", tx, 1);
      check("t5_busy_after_reset", busy, 0);
      check("t5_fifo_kept", fifo_q.size(), 1);
      step();
      enable = 1'b1;
      wait_idle("t5_resume");
      step();
      check("t5_frames", frame_starts.size() - fs0, 2);

      // Random words with random enable gaps.
      for (int i = 0; i < 12; i++) begin
         w = 16'($urandom);
         push_word(w);
         if ($urandom_range(0, 3) == 0) begin
            enable = 1'b0;
            repeat ($urandom_range(5, 60)) @(posedge clk);
            #2 enable = 1'b1;
         end
         repeat ($urandom_range(0, 50)) @(posedge clk);
         #2;
      end
      wait_idle("rand_drain");
      step();
      check("rand_exp_drained", exp_q.size(), 0);

      // Two-stop-bit build: 44-cycle frame with an 8-cycle stop.
      b       = 8'($urandom_range(0, 255));
      r_data2 = b;
      empty2  = 1'b0;
      enable2 = 1'b1;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (rd2 === 1'b1) break;
         n++;
      end
      if (n >= 50) check("t6_rd_timeout", 1, 0);
      @(posedge clk);
      #1 empty2 = 1'b1;
      for (int k = 0; k < FRAME2; k++) begin
         @(negedge clk);
         pos = k / CPB;
         if (pos == 0) lvl = 1'b0;
         else if (pos > DW) lvl = 1'b1;
         else lvl = b[pos-1];
         check("t6_line", {30'd0, busy2, tx2}, {30'd0, 1'b1, lvl});
      end
      @(negedge clk);
      check("t6_end_tx", tx2, 1);
      check("t6_end_busy", busy2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
